// File: rtl/uart_tx_arbiter.sv
// Purpose: arbitrates two FIFO channels onto one shared uart_tx, one word per transfer,
//          with bounded bursts (MAX_BURST) so a busy channel cannot starve the other.
// Latency: request sampled in IDLE at edge N -> o_r_en in cycle N+1, o_dv in cycle N+3.
// Backpressure: waits for uart_tx busy to rise then fall; a 4-cycle guard recovers a lost busy handshake.
// Ports: clk/i_reset (sync, active-high); i_tx_enable gates new words; i_empty/i_r_data0/1 from FIFOs;
//        i_busy from uart_tx; o_r_en FIFO read strobes; o_dv/o_data to uart_tx; o_grant owner; o_words_sent count.
module uart_tx_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic             i_tx_enable,
    input  logic [1:0]       i_empty,
    input  logic [WIDTH-1:0] i_r_data0,
    input  logic [WIDTH-1:0] i_r_data1,
    input  logic             i_busy,
    output logic [1:0]       o_r_en,
    output logic             o_dv,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_grant,
    output logic [15:0]      o_words_sent
);

    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        SEND,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       grant;
    logic             last_grant;
    logic [3:0]       burst_cnt;
    logic [1:0]       wb_cnt;
    logic [WIDTH-1:0] data_q;
    logic [15:0]      words_cnt;

    logic [1:0]       req;
    logic             start;
    logic             pick;

    assign req   = ~i_empty;
    assign start = (state == IDLE) && i_tx_enable && !i_busy && (req != 2'b00);

    // Channel selection. A burst count of zero means no burst is in progress
    // (only true after reset), so the channel that was not last granted wins;
    // this is what hands the first contest after reset to channel 0.
    always_comb begin
        pick = 1'b0;
        if (req == 2'b01) begin
            pick = 1'b0;
        end else if (req == 2'b10) begin
            pick = 1'b1;
        end else if ((burst_cnt != 4'd0) && (burst_cnt < BURST_MAX)) begin
            pick = last_grant;
        end else begin
            pick = ~last_grant;
        end
    end

    // Next-state and strobe outputs.
    always_comb begin
        state_nxt = state;
        o_r_en    = 2'b00;
        o_dv      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                o_r_en    = grant;
                state_nxt = LATCH;
            end
            LATCH: begin
                state_nxt = SEND;
            end
            SEND: begin
                o_dv      = 1'b1;
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // Give up after 4 cycles without busy so a dropped handshake cannot hang the channel.
                if (i_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (wb_cnt == 2'd3) begin
                    state_nxt = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!i_busy) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state      <= IDLE;
            grant      <= 2'b00;
            last_grant <= 1'b1;
            burst_cnt  <= 4'd0;
            wb_cnt     <= 2'd0;
            data_q     <= '0;
            words_cnt  <= 16'd0;
        end else begin
            state <= state_nxt;

            if (start) begin
                grant      <= pick ? 2'b10 : 2'b01;
                last_grant <= pick;
                if (pick == last_grant) begin
                    if (burst_cnt < BURST_MAX) begin
                        burst_cnt <= burst_cnt + 4'd1;
                    end
                end else begin
                    burst_cnt <= 4'd1;
                end
            end else if (state_nxt == IDLE) begin
                grant <= 2'b00;
            end

            // FIFO data is valid the cycle after the read strobe, i.e. during LATCH.
            if (state == LATCH) begin
                data_q <= grant[1] ? i_r_data1 : i_r_data0;
            end

            if (state == SEND) begin
                words_cnt <= words_cnt + 16'd1;
            end

            if (state == WAIT_BUSY) begin
                wb_cnt <= wb_cnt + 2'd1;
            end else begin
                wb_cnt <= 2'd0;
            end
        end
    end

    assign o_data       = data_q;
    assign o_grant      = grant;
    assign o_words_sent = words_cnt;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_tx_enable = 1'b0;
    logic [1:0]  i_empty = 2'b11;
    logic [7:0]  i_r_data0 = 8'h00;
    logic [7:0]  i_r_data1 = 8'h00;
    logic        i_busy = 1'b0;
    logic [1:0]  o_r_en;
    logic        o_dv;
    logic [7:0]  o_data;
    logic [1:0]  o_grant;
    logic [15:0] o_words_sent;

    uart_tx_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
        .clk          (clk),
        .i_reset      (i_reset),
        .i_tx_enable  (i_tx_enable),
        .i_empty      (i_empty),
        .i_r_data0    (i_r_data0),
        .i_r_data1    (i_r_data1),
        .i_busy       (i_busy),
        .o_r_en       (o_r_en),
        .o_dv         (o_dv),
        .o_data       (o_data),
        .o_grant      (o_grant),
        .o_words_sent (o_words_sent)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Observation state shared with the monitor.
    int         cyc = 0;
    int         rd_total = 0;
    int         rd0 = 0;
    int         rd1 = 0;
    int         dv_total = 0;
    int         reads_since_dv = 0;
    int         busy_len = 0;
    int         busy_left = 0;
    logic [1:0] grant_q[$];
    int         rd_cyc_q[$];

    // Monitor + uart_tx busy model, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (o_r_en != 2'b00) begin
                rd_total++;
                reads_since_dv++;
                if (o_r_en == 2'b01) rd0++;
                if (o_r_en == 2'b10) rd1++;
                grant_q.push_back(o_grant);
                rd_cyc_q.push_back(cyc);
                check_eq("ren_vs_grant", {30'd0, o_r_en}, {30'd0, o_grant});
            end
            if (o_dv) begin
                dv_total++;
                check_eq("one_read_per_dv", reads_since_dv, 1);
                reads_since_dv = 0;
                check_eq("dv_data", {24'd0, o_data},
                         {24'd0, (o_grant == 2'b10) ? i_r_data1 : i_r_data0});
                if (busy_len > 0) busy_left = busy_len;
            end
            if (busy_left > 0) begin
                i_busy = 1'b1;
                busy_left--;
            end else begin
                i_busy = 1'b0;
            end
        end
    end

    // One reset edge; returns just after the following falling edge with reset released.
    task automatic do_reset();
        i_reset = 1'b1;
        @(negedge clk);
        #1;
        busy_left      = 0;
        i_busy         = 1'b0;
        rd_total       = 0;
        rd0            = 0;
        rd1            = 0;
        dv_total       = 0;
        reads_since_dv = 0;
        grant_q.delete();
        rd_cyc_q.delete();
        i_reset = 1'b0;
    endtask

    task automatic wait_reads(input int n, input int maxc, input string tag);
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            #2;
            if (rd_total >= n) break;
        end
        check_eq(tag, rd_total, n);
    endtask

    task automatic wait_dvs(input int n, input int maxc, input string tag);
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            #2;
            if (dv_total >= n) break;
        end
        check_eq(tag, dv_total, n);
    endtask

    task automatic wait_idle(input int maxc, input string tag);
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            #2;
            if (o_grant == 2'b00) break;
        end
        check_eq(tag, {30'd0, o_grant}, 32'd0);
    endtask

    initial begin
        @(negedge clk);

        // Reset state.
        do_reset();
        check_eq("rst_r_en", {30'd0, o_r_en}, 0);
        check_eq("rst_dv", {31'd0, o_dv}, 0);
        check_eq("rst_data", {24'd0, o_data}, 0);
        check_eq("rst_grant", {30'd0, o_grant}, 0);
        check_eq("rst_words", {16'd0, o_words_sent}, 0);

        // Single channel, uart busy for 10 cycles.
        i_tx_enable = 1'b1;
        i_r_data0   = 8'hAA;
        busy_len    = 10;
        #1;
        i_empty = 2'b10;
        @(negedge clk);
        check_eq("single_ren_n1", {30'd0, o_r_en}, 32'h1);
        check_eq("single_grant", {30'd0, o_grant}, 32'h1);
        check_eq("single_dv_n1", {31'd0, o_dv}, 0);
        i_empty = 2'b11;
        @(negedge clk);
        check_eq("single_ren_n2", {30'd0, o_r_en}, 0);
        check_eq("single_dv_n2", {31'd0, o_dv}, 0);
        @(negedge clk);
        check_eq("single_dv_n3", {31'd0, o_dv}, 1);
        check_eq("single_data", {24'd0, o_data}, 32'hAA);
        wait_idle(40, "single_idle");
        check_eq("single_words", {16'd0, o_words_sent}, 1);
        check_eq("single_reads", rd_total, 1);
        check_eq("single_dvs", dv_total, 1);
        check_eq("single_data_hold", {24'd0, o_data}, 32'hAA);

        // Fairness: both channels always requesting.
        do_reset();
        i_r_data0 = 8'h11;
        i_r_data1 = 8'h22;
        busy_len  = 2;
        i_empty   = 2'b00;
        wait_reads(16, 400, "fair_reads");
        i_empty = 2'b11;
        wait_idle(40, "fair_idle");
        check_eq("fair_dvs", dv_total, 16);
        for (int i = 0; i < 16; i++) begin
            logic [1:0] exp_g;
            exp_g = ((i / 4) % 2 == 0) ? 2'b01 : 2'b10;
            if (i < grant_q.size())
                check_eq($sformatf("fair_grant%0d", i), {30'd0, grant_q[i]}, {30'd0, exp_g});
        end
        check_eq("fair_ch0", rd0, 8);
        check_eq("fair_ch1", rd1, 8);
        check_eq("fair_words", {16'd0, o_words_sent}, 16);

        // Enable gating during WAIT_DONE of word 3.
        do_reset();
        busy_len = 6;
        i_empty  = 2'b00;
        wait_dvs(3, 100, "gate_dv3");
        @(negedge clk);
        @(negedge clk);
        #2;
        i_tx_enable = 1'b0;
        repeat (40) @(negedge clk);
        #2;
        check_eq("gate_reads", rd_total, 3);
        check_eq("gate_words", {16'd0, o_words_sent}, 3);
        check_eq("gate_grant", {30'd0, o_grant}, 0);
        i_tx_enable = 1'b1;
        wait_reads(4, 2, "gate_reenable");
        i_empty = 2'b11;
        wait_idle(40, "gate_idle");

        // Lost handshake: busy never rises.
        do_reset();
        busy_len = 0;
        i_empty  = 2'b10;
        wait_reads(3, 60, "lost_reads");
        i_empty = 2'b11;
        wait_idle(20, "lost_idle");
        if (rd_cyc_q.size() >= 3) begin
            check_eq("lost_gap1", rd_cyc_q[1] - rd_cyc_q[0], 8);
            check_eq("lost_gap2", rd_cyc_q[2] - rd_cyc_q[1], 8);
        end
        check_eq("lost_words", {16'd0, o_words_sent}, 3);

        // Reset in WAIT_BUSY after a channel-1 word; next contest goes to channel 0.
        do_reset();
        busy_len = 0;
        i_empty  = 2'b01;
        wait_dvs(1, 20, "mid_dv");
        i_empty = 2'b11;
        @(negedge clk);
        do_reset();
        check_eq("mid_r_en", {30'd0, o_r_en}, 0);
        check_eq("mid_dv", {31'd0, o_dv}, 0);
        check_eq("mid_data", {24'd0, o_data}, 0);
        check_eq("mid_grant", {30'd0, o_grant}, 0);
        check_eq("mid_words", {16'd0, o_words_sent}, 0);
        i_empty = 2'b00;
        wait_reads(1, 10, "mid_read");
        if (grant_q.size() >= 1)
            check_eq("mid_first_grant", {30'd0, grant_q[0]}, 32'h1);
        i_empty = 2'b11;
        wait_idle(20, "mid_idle");

        // Counter wrap.
        do_reset();
        force dut.words_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.words_cnt;
        @(negedge clk);
        check_eq("wrap_pre", {16'd0, o_words_sent}, 32'hFFFF);
        busy_len = 2;
        #2;
        i_empty = 2'b10;
        wait_dvs(1, 10, "wrap_dv");
        i_empty = 2'b11;
        @(negedge clk);
        check_eq("wrap_words", {16'd0, o_words_sent}, 0);
        wait_idle(20, "wrap_idle");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: word width in bits for both FIFO read-data inputs and o_data.
REQ-002 Parameter MAX_BURST, default 4: maximum consecutive words granted to one channel while the other channel is requesting; legal range 1..15.
REQ-003 clk  input  1  single clock; all logic on posedge.
REQ-004 i_reset  input  1  synchronous, active-high reset.
REQ-005 i_tx_enable  input  1  when low, no new word is started.
REQ-006 i_empty  input  2  per-channel FIFO empty flag; bit k=1 means channel k has no data.
REQ-007 i_r_data0, i_r_data1  input  WIDTH each  FIFO read data for channels 0 and 1, valid the cycle after the matching o_r_en bit.
REQ-008 i_busy  input  1  busy flag from the shared uart_tx.
REQ-009 o_r_en  output  2  one-hot FIFO read strobe per channel.
REQ-010 o_dv  output  1  one-cycle data-valid strobe to uart_tx.
REQ-011 o_data  output  WIDTH  word presented to uart_tx.
REQ-012 o_grant  output  2  one-hot; the channel owning the current transfer, 0 when IDLE.
REQ-013 o_words_sent  output  16  count of words handed to uart_tx.

Function
REQ-014 FSM states SHALL be IDLE, READ, LATCH, SEND, WAIT_BUSY, WAIT_DONE, in that fixed sequence, returning to IDLE after WAIT_DONE.
REQ-015 IDLE -> READ SHALL occur when i_tx_enable=1, i_busy=0, and at least one i_empty bit is 0; otherwise remain in IDLE.
REQ-016 On the IDLE -> READ transition, the arbiter SHALL select channel k per REQ-017/018 and latch it into o_grant.
REQ-017 Only one channel requesting: grant that channel.
REQ-018 Both requesting: grant the last-granted channel if its burst count < MAX_BURST, else the other channel; after reset the last-granted channel is 1, so channel 0 wins the first contest.
REQ-019 Burst count SHALL increment on each grant to the same channel as last grant, reset to 1 on a grant to a different channel, and saturate at MAX_BURST.
REQ-020 READ (exactly 1 cycle): o_r_en[k]=1, other bit 0; o_r_en SHALL be 0 in every other state.
REQ-021 LATCH (1 cycle): o_data <= i_r_data<k>; o_data SHALL hold that value until the next LATCH.
REQ-022 SEND (1 cycle): o_dv=1; o_words_sent increments by 1, wrapping 16'hFFFF -> 16'h0000.
REQ-023 Latency: i_empty[k] falling, sampled in IDLE at edge N, gives o_r_en[k] high in cycle N+1, o_dv high in cycle N+3.
REQ-024 WAIT_BUSY SHALL remain until i_busy=1, then go to WAIT_DONE; if i_busy has not risen after 4 cycles in WAIT_BUSY, go directly to IDLE (lost-handshake guard).
REQ-025 WAIT_DONE SHALL remain until i_busy=0, then go to IDLE with o_grant=0.
REQ-026 i_tx_enable falling mid-transfer (READ..WAIT_DONE) SHALL NOT abort; the word completes and the FSM parks in IDLE until enable returns.
REQ-027 i_empty changes after the grant SHALL NOT affect the transfer in progress; the word is read regardless.
REQ-028 o_dv SHALL never be asserted twice without an intervening o_r_en pulse; exactly one FIFO read per word sent.

Reset
REQ-029 When i_reset=1 at a clock edge: state=IDLE, o_r_en=0, o_dv=0, o_data=0, o_grant=0, o_words_sent=0, burst count=0, last-granted=1.
REQ-030 Reset SHALL take priority over every transition, including mid-transfer; no o_dv or o_r_en in the cycle after reset is sampled.

Verification
REQ-031 Single channel: i_empty=2'b10, i_r_data0=8'hAA, uart_tx busy for 10 cycles -> o_r_en=2'b01 one cycle, o_data=8'hAA, o_dv one pulse at N+3, o_words_sent=1.
REQ-032 Fairness: both channels always non-empty, MAX_BURST=4 -> grant sequence 0,0,0,0,1,1,1,1,0,...; 16 words give 8 per channel.
REQ-033 Enable gating: i_tx_enable dropped during WAIT_DONE of word 3 -> word 3 completes, no further o_r_en for 40 cycles; re-enable -> next read within 2 cycles.
REQ-034 Lost handshake: i_busy tied 0 -> each word leaves WAIT_BUSY after 4 cycles; the next read starts, with no hang.
REQ-035 Reset mid-transfer: i_reset asserted in WAIT_BUSY -> all outputs 0 next cycle, o_words_sent=0, next grant to channel 0 when both request.
REQ-036 Wrap: preload 65535 words' worth (or force counter) then send one -> o_words_sent=16'h0000.
